// File: rtl/ahb_lite_pkg.sv
// Shared types and constants for the AHB-Lite style RAM responder.
package ahb_lite_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  // Responder FSM states; S_ERR is only reachable when error responses are enabled
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_lite_regfile.sv
// Byte-wide storage for the RAM responder: one synchronous write port,
// one combinational read port, every word cleared by reset.
// Addresses at or above DEPTH are never written and read back as zero.
module ahb_lite_regfile
  import ahb_lite_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              i_wrEn,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic [ADDR_W-1:0] i_rdAddr,
  output logic [DATA_W-1:0] o_rdData
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_wrOk;
  logic              w_rdOk;
  logic [IDX_W-1:0]  w_wrIdx;
  logic [IDX_W-1:0]  w_rdIdx;

  assign w_wrOk  = i_wrEn && ({1'b0, i_wrAddr} < 9'(DEPTH));
  assign w_rdOk  = {1'b0, i_rdAddr} < 9'(DEPTH);
  assign w_wrIdx = i_wrAddr[IDX_W-1:0];
  assign w_rdIdx = i_rdAddr[IDX_W-1:0];

  // Clear all words on reset, otherwise write one in-range word per enabled edge
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wrOk) begin
      r_mem[w_wrIdx] <= i_wrData;
    end
  end

  // Combinational read; out-of-range addresses return zero
  always_comb begin
    o_rdData = '0;
    if (w_rdOk) begin
      o_rdData = r_mem[w_rdIdx];
    end
  end

endmodule

// File: rtl/ahb_lite_ram_responder.sv
// Simple AHB-Lite style RAM responder: captures a transfer in IDLE, inserts
// WAIT wait states, then returns registered readyout/rdata/resp.
// The registered outputs are loaded while the FSM sits in RESP, so readyout
// becomes visible WAIT+1 edges after the capturing edge.
// Optional feature macro ERROR_RESP_EN: out-of-range transfers get a
// two-cycle ERROR response (ERR then RESP) instead of an OKAY response.
module ahb_lite_ram_responder
  import ahb_lite_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WAIT  = 1
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              trans,
  input  logic              write,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic              readyout,
  output logic [DATA_W-1:0] rdata,
  output logic              resp
);

  localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  state_t            r_state;
  state_t            w_nextState;
  state_t            w_respState;
  logic [3:0]        r_cnt;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_ready;
  logic              r_resp;
  logic [DATA_W-1:0] r_rdata;

  logic              w_take;
  logic              w_curWrite;
  logic [ADDR_W-1:0] w_curAddr;
  logic [DATA_W-1:0] w_curWdata;
  logic              w_curInRange;
  logic              w_capInRange;
  logic              w_wrEn;
  logic [DATA_W-1:0] w_memRdata;
  logic              w_oorResp;

  // With WAIT=0 the write happens on the capturing edge itself, so the
  // transfer fields come straight from the inputs while in IDLE.
  assign w_take       = (r_state == S_IDLE) && trans;
  assign w_curWrite   = (r_state == S_IDLE) ? write : r_write;
  assign w_curAddr    = (r_state == S_IDLE) ? waddr : r_addr;
  assign w_curWdata   = (r_state == S_IDLE) ? wdata : r_wdata;
  assign w_curInRange = {1'b0, w_curAddr} < 9'(DEPTH);
  assign w_capInRange = {1'b0, r_addr} < 9'(DEPTH);

`ifdef ERROR_RESP_EN
  assign w_respState = w_curInRange ? S_RESP : S_ERR;
  assign w_oorResp   = RESP_ERROR;
`else
  assign w_respState = S_RESP;
  assign w_oorResp   = RESP_OKAY;
`endif

  assign w_wrEn = (w_nextState == S_RESP) &&
                  ((r_state == S_IDLE) || (r_state == S_WAIT)) &&
                  w_curWrite && w_curInRange;

  ahb_lite_regfile #(
    .DEPTH (DEPTH)
  ) uRegfile (
    .clock    (clock),
    .rst_n    (rst_n),
    .i_wrEn   (w_wrEn),
    .i_wrAddr (w_curAddr),
    .i_wrData (w_curWdata),
    .i_rdAddr (r_addr),
    .o_rdData (w_memRdata)
  );

  // State register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: IDLE -> (WAIT) -> (ERR) -> RESP -> IDLE
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (trans) w_nextState = (WAIT > 0) ? S_WAIT : w_respState;
      S_WAIT:  if (r_cnt == 4'd0) w_nextState = w_respState;
      S_ERR:   w_nextState = S_RESP;
      S_RESP:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Capture the transfer fields only when a request is accepted in IDLE
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_take) begin
      r_write <= write;
      r_addr  <= waddr;
      r_wdata <= wdata;
    end
  end

  // Wait-state down-counter, loaded on acceptance and run down in WAIT
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (w_take) begin
      r_cnt <= WAIT_LOAD;
    end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Registered response outputs; rdata holds its value outside a response
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b0;
      r_resp  <= RESP_OKAY;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_RESP: begin
          r_ready <= 1'b1;
          if (!w_capInRange) begin
            r_resp  <= w_oorResp;
            r_rdata <= '0;
          end else begin
            r_resp  <= RESP_OKAY;
            r_rdata <= r_write ? r_wdata : w_memRdata;
          end
        end
        S_ERR: begin
          r_ready <= 1'b0;
          r_resp  <= RESP_ERROR;
        end
        default: begin
          r_ready <= 1'b0;
          r_resp  <= RESP_OKAY;
        end
      endcase
    end
  end

  assign readyout = r_ready;
  assign rdata    = r_rdata;
  assign resp     = r_resp;

endmodule

// File: tb/tb_ahb_lite_ram_responder.sv
// Directed bench for ahb_lite_ram_responder. Three instances with DEPTH=16
// and WAIT=1, WAIT=0 and WAIT=3 share one clock; expectations follow
// ERROR_RESP_EN when the macro is defined for the build.
module tb_ahb_lite_ram_responder;

  logic             clock;
  logic [2:0]       rstN;
  logic [2:0]       trans;
  logic [2:0]       writeIn;
  logic [2:0][7:0]  waddr;
  logic [2:0][7:0]  wdata;
  logic [2:0]       readyout;
  logic [2:0][7:0]  rdata;
  logic [2:0]       resp;

  int checkCount;
  int errorCount;

  logic [7:0] gotData;
  logic       gotResp;
  int         gotLat;
  bit         gotErr;
  bit         gotStuck;
  bit         sawReady;
  logic [7:0] b2bWrData [6];
  logic       b2bWrite  [6];
  logic [7:0] b2bExp    [6];

  // Free-running clock, period 10
  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : gDut
    ahb_lite_ram_responder #(
      .DEPTH (16),
      .WAIT  ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) uDut (
      .clock    (clock),
      .rst_n    (rstN[g]),
      .trans    (trans[g]),
      .write    (writeIn[g]),
      .waddr    (waddr[g]),
      .wdata    (wdata[g]),
      .readyout (readyout[g]),
      .rdata    (rdata[g]),
      .resp     (resp[g])
    );
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one transfer on instance sel and wait (bounded) for readyout
  task automatic applyStimulus(input int sel, input logic wr, input logic [7:0] addr,
                               input logic [7:0] data, input bit disturb,
                               output logic [7:0] oData, output logic oResp,
                               output int oLat, output bit oErr, output bit oStuck);
    writeIn[sel] = wr;
    waddr[sel]   = addr;
    wdata[sel]   = data;
    trans[sel]   = 1'b1;
    tick();
    trans[sel] = 1'b0;
    if (disturb) begin
      waddr[sel]   = addr ^ 8'h0D;
      wdata[sel]   = ~data;
      writeIn[sel] = ~wr;
    end
    oLat  = 0;
    oErr  = 1'b0;
    oData = 8'h00;
    oResp = 1'b0;
    for (int k = 1; k <= 40 && oLat == 0; k++) begin
      tick();
      if (readyout[sel]) begin
        oLat  = k;
        oData = rdata[sel];
        oResp = resp[sel];
      end else if (resp[sel]) begin
        oErr = 1'b1;
      end
    end
    tick();
    oStuck = readyout[sel];
  endtask

  // Run a transfer and check data, response, latency, error cycle and pulse width
  task automatic runTransfer(input string tag, input int sel, input logic wr,
                             input logic [7:0] addr, input logic [7:0] data,
                             input bit disturb, input logic [7:0] expData,
                             input logic expResp, input int expLat, input bit expErr);
    logic [7:0] d;
    logic       r;
    int         lat;
    bit         e;
    bit         s;
    applyStimulus(sel, wr, addr, data, disturb, d, r, lat, e, s);
    checkOutput({tag, "_latency"}, lat, expLat);
    checkOutput({tag, "_rdata"}, d, expData);
    checkOutput({tag, "_resp"}, r, expResp);
    checkOutput({tag, "_errcycle"}, e, expErr);
    checkOutput({tag, "_pulse"}, s, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount = 0;
    errorCount = 0;
    rstN    = 3'b000;
    trans   = 3'b000;
    writeIn = 3'b000;
    waddr   = '0;
    wdata   = '0;
    b2bWrite  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    b2bWrData = '{8'h11, 8'h00, 8'h22, 8'h00, 8'h33, 8'h00};
    b2bExp    = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};

    // Reset values are forced while rst_n is low, before any clock edge
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset_readyout%0d", i), readyout[i], 1'b0);
      checkOutput($sformatf("reset_rdata%0d", i), rdata[i], 8'h00);
      checkOutput($sformatf("reset_resp%0d", i), resp[i], 1'b0);
    end
    tick();
    tick();
    rstN = 3'b111;
    tick();

    $display("[TB] sweep reads after reset, WAIT=1");
    for (int a = 0; a < 16; a++) begin
      runTransfer($sformatf("sweep%0d", a), 0, 1'b0, 8'(a), 8'h00, 1'b0, 8'h00, 1'b0, 2, 1'b0);
    end

    $display("[TB] write/read address 3, WAIT=1");
    runTransfer("wr3", 0, 1'b1, 8'd3, 8'hA5, 1'b0, 8'hA5, 1'b0, 2, 1'b0);
    runTransfer("rd3", 0, 1'b0, 8'd3, 8'h00, 1'b0, 8'hA5, 1'b0, 2, 1'b0);

    $display("[TB] inputs changed during WAIT");
    runTransfer("wr9dist", 0, 1'b1, 8'd9, 8'h5A, 1'b1, 8'h5A, 1'b0, 2, 1'b0);
    runTransfer("rd9", 0, 1'b0, 8'd9, 8'h00, 1'b0, 8'h5A, 1'b0, 2, 1'b0);
    runTransfer("rd4", 0, 1'b0, 8'd4, 8'h00, 1'b0, 8'h00, 1'b0, 2, 1'b0);

    $display("[TB] out-of-range transfers");
`ifdef ERROR_RESP_EN
    runTransfer("oor_rd", 0, 1'b0, 8'h20, 8'h00, 1'b0, 8'h00, 1'b1, 3, 1'b1);
    applyStimulus(0, 1'b1, 8'h13, 8'h77, 1'b0, gotData, gotResp, gotLat, gotErr, gotStuck);
    checkOutput("oor_wr_resp", gotResp, 1'b1);
    checkOutput("oor_wr_latency", gotLat, 3);
`else
    runTransfer("oor_rd", 0, 1'b0, 8'h20, 8'h00, 1'b0, 8'h00, 1'b0, 2, 1'b0);
    applyStimulus(0, 1'b1, 8'h13, 8'h77, 1'b0, gotData, gotResp, gotLat, gotErr, gotStuck);
    checkOutput("oor_wr_resp", gotResp, 1'b0);
    checkOutput("oor_wr_latency", gotLat, 2);
`endif
    runTransfer("rd3_after_oor", 0, 1'b0, 8'd3, 8'h00, 1'b0, 8'hA5, 1'b0, 2, 1'b0);

    $display("[TB] back-to-back address 7, WAIT=0");
    writeIn[1] = b2bWrite[0];
    waddr[1]   = 8'd7;
    wdata[1]   = b2bWrData[0];
    trans[1]   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput($sformatf("b2b%0d_gap", i), readyout[1], 1'b0);
      if (i < 5) begin
        writeIn[1] = b2bWrite[i+1];
        wdata[1]   = b2bWrData[i+1];
      end else begin
        trans[1] = 1'b0;
      end
      tick();
      checkOutput($sformatf("b2b%0d_ready", i), readyout[1], 1'b1);
      checkOutput($sformatf("b2b%0d_rdata", i), rdata[1], b2bExp[i]);
      checkOutput($sformatf("b2b%0d_resp", i), resp[1], 1'b0);
    end
    tick();

    $display("[TB] reset during WAIT, WAIT=3");
    runTransfer("wr5", 2, 1'b1, 8'd5, 8'h99, 1'b0, 8'h99, 1'b0, 4, 1'b0);
    writeIn[2] = 1'b1;
    waddr[2]   = 8'd2;
    wdata[2]   = 8'h3C;
    trans[2]   = 1'b1;
    tick();
    trans[2] = 1'b0;
    tick();
    checkOutput("abort_hold_rdata", rdata[2], 8'h99);
    #2;
    rstN[2] = 1'b0;
    #1;
    checkOutput("abort_rdata", rdata[2], 8'h00);
    checkOutput("abort_readyout", readyout[2], 1'b0);
    checkOutput("abort_resp", resp[2], 1'b0);
    sawReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (readyout[2]) sawReady = 1'b1;
    end
    rstN[2] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (readyout[2]) sawReady = 1'b1;
    end
    checkOutput("abort_no_pulse", sawReady, 1'b0);
    runTransfer("rd2_after_abort", 2, 1'b0, 8'd2, 8'h00, 1'b0, 8'h00, 1'b0, 4, 1'b0);
    runTransfer("rd5_after_reset", 2, 1'b0, 8'd5, 8'h00, 1'b0, 8'h00, 1'b0, 4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
